// File: rtl/wb_tdpbram_be.sv
// wb_tdpbram_be: true dual-port block RAM with per-lane write enables.
// After reset the controller sweeps zero through every word, one per cycle,
// before accepting requests. Reads are read-first on both ports. When both
// ports write the same word, a lane enabled on both ports takes port A data.
// Optional macro WB_TDPBRAM_BE_OUTREG_EN adds one output register stage
// (read latency 2); without it the read latency is 1.
//
// state | meaning
// CLEAR | zero sweep in progress, requests ignored, o_ready = 0
// READY | sweep done, port requests serviced, o_ready = 1
module wb_tdpbram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BYTE_WIDTH = 8,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  output logic                             o_ready,
  input  logic                             i_enA,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_weA,
  input  logic [ADDR_WIDTH-1:0]            i_addrA,
  input  logic [DATA_WIDTH-1:0]            i_dinA,
  output logic [DATA_WIDTH-1:0]            o_doutA,
  output logic                             o_validA,
  input  logic                             i_enB,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_weB,
  input  logic [ADDR_WIDTH-1:0]            i_addrB,
  input  logic [DATA_WIDTH-1:0]            i_dinB,
  output logic [DATA_WIDTH-1:0]            o_doutB,
  output logic                             o_validB,
  output logic                             o_collision
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [DATA_WIDTH-1:0]   dout_a, dout_b;
  logic                    valid_a, valid_b, collision;

  logic                    in_range_a, in_range_b;
  logic                    acc_a, acc_b;
  logic                    wr_a, wr_b;
  logic                    same_word_write;

  assign in_range_a = {1'b0, i_addrA} < DEPTH_EXT;
  assign in_range_b = {1'b0, i_addrB} < DEPTH_EXT;
  assign acc_a      = (state == READY) && i_enA;
  assign acc_b      = (state == READY) && i_enB;
  assign wr_a       = acc_a && in_range_a;
  assign wr_b       = acc_b && in_range_b;
  assign same_word_write = acc_a && acc_b && in_range_a && (i_addrA == i_addrB)
                           && ((|i_weA) || (|i_weB));

  // Storage: zero sweep in CLEAR, lane writes in READY. Port A lanes are
  // issued after port B so A wins any lane both ports write.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state == CLEAR) begin
        mem[sweep_addr] <= '0;
      end else begin
        for (int k = 0; k < NB; k++) begin
          if (wr_b && i_weB[k])
            mem[i_addrB][k*BYTE_WIDTH +: BYTE_WIDTH] <= i_dinB[k*BYTE_WIDTH +: BYTE_WIDTH];
          if (wr_a && i_weA[k])
            mem[i_addrA][k*BYTE_WIDTH +: BYTE_WIDTH] <= i_dinA[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Controller FSM plus registered read data, valids and collision flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= CLEAR;
      sweep_addr <= '0;
      o_ready    <= 1'b0;
      dout_a     <= '0;
      dout_b     <= '0;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
      collision  <= 1'b0;
    end else begin
      valid_a   <= 1'b0;
      valid_b   <= 1'b0;
      collision <= 1'b0;
      case (state)
        CLEAR: begin
          if (sweep_addr == SWEEP_LAST) begin
            state   <= READY;
            o_ready <= 1'b1;
          end else begin
            sweep_addr <= sweep_addr + 1'b1;
          end
        end
        READY: begin
          if (acc_a) begin
            dout_a  <= in_range_a ? mem[i_addrA] : '0;
            valid_a <= 1'b1;
          end
          if (acc_b) begin
            dout_b  <= in_range_b ? mem[i_addrB] : '0;
            valid_b <= 1'b1;
          end
          collision <= same_word_write;
        end
        default: state <= CLEAR;
      endcase
    end
  end

`ifdef WB_TDPBRAM_BE_OUTREG_EN
  logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;
  logic                  valid_a_q, valid_b_q, collision_q;

  // Extra output stage; valids and collision travel with the data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dout_a_q    <= '0;
      dout_b_q    <= '0;
      valid_a_q   <= 1'b0;
      valid_b_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      dout_a_q    <= dout_a;
      dout_b_q    <= dout_b;
      valid_a_q   <= valid_a;
      valid_b_q   <= valid_b;
      collision_q <= collision;
    end
  end

  assign o_doutA     = dout_a_q;
  assign o_doutB     = dout_b_q;
  assign o_validA    = valid_a_q;
  assign o_validB    = valid_b_q;
  assign o_collision = collision_q;
`else
  assign o_doutA     = dout_a;
  assign o_doutB     = dout_b;
  assign o_validA    = valid_a;
  assign o_validB    = valid_b;
  assign o_collision = collision;
`endif

endmodule
